// File: rtl/dac_intlv_pkg.sv
// rtl/dac_intlv_pkg.sv - shared types and constants for the interleaved DAC slot scheduler
package dac_intlv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLOT_A = 2'd1,
        SLOT_B = 2'd2
    } state_e;

    localparam int CH_A   = 0;
    localparam int CH_B   = 1;
    localparam int DW_DEF = 14;
    localparam int CW_DEF = 16;

endpackage

// File: rtl/dac_urun_cnt.sv
// rtl/dac_urun_cnt.sv - saturating underrun counter; synchronous clear has priority over increment
module dac_urun_cnt #(
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dac_intlv_ctrl.sv
// rtl/dac_intlv_ctrl.sv - A/B slot scheduler for the shared DAC bus; DAC_URUN_ZERO_EN selects zero-fill on underrun
module dac_intlv_ctrl
    import dac_intlv_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic            dac_clk_i,
    input  logic            dac_rst_i,
    input  logic            ena_i,
    input  logic [DW-1:0]   cha_dat_i,
    input  logic            cha_vld_i,
    output logic            cha_rdy_o,
    input  logic [DW-1:0]   chb_dat_i,
    input  logic            chb_vld_i,
    output logic            chb_rdy_o,
    input  logic            urun_clr_i,
    output logic [DW-1:0]   dac_dat_o,
    output logic            dac_sel_o,
    output logic            dac_wrt_o,
    output logic            active_o,
    output logic [2*CW-1:0] urun_cnt_o
);

    state_e        state_q, state_d;
    logic [DW-1:0] hold_a_q, hold_a_d;
    logic [DW-1:0] hold_b_q, hold_b_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          sel_q, sel_d;
    logic          wrt_q, wrt_d;
    logic          urun_a, urun_b;

    always_comb begin
        state_d  = state_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        wrt_d    = 1'b1;
        urun_a   = 1'b0;
        urun_b   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena_i) state_d = SLOT_A;
            end
            SLOT_A: begin
                // B always follows A so a started pair is never split
                state_d = SLOT_B;
                sel_d   = 1'b0;
                wrt_d   = 1'b0;
                if (cha_vld_i) begin
                    hold_a_d = cha_dat_i;
                    dat_d    = cha_dat_i;
                end else begin
                    urun_a = 1'b1;
`ifdef DAC_URUN_ZERO_EN
                    dat_d    = '0;
                    hold_a_d = '0;
`else
                    dat_d    = hold_a_q;
`endif
                end
            end
            SLOT_B: begin
                state_d = ena_i ? SLOT_A : IDLE;
                sel_d   = 1'b1;
                wrt_d   = 1'b0;
                if (chb_vld_i) begin
                    hold_b_d = chb_dat_i;
                    dat_d    = chb_dat_i;
                end else begin
                    urun_b = 1'b1;
`ifdef DAC_URUN_ZERO_EN
                    dat_d    = '0;
                    hold_b_d = '0;
`else
                    dat_d    = hold_b_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state_q  <= IDLE;
            hold_a_q <= '0;
            hold_b_q <= '0;
            dat_q    <= '0;
            sel_q    <= 1'b0;
            wrt_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            wrt_q    <= wrt_d;
        end
    end

    assign cha_rdy_o = (state_q == SLOT_A);
    assign chb_rdy_o = (state_q == SLOT_B);
    assign active_o  = (state_q != IDLE);
    assign dac_dat_o = dat_q;
    assign dac_sel_o = sel_q;
    assign dac_wrt_o = wrt_q;

    dac_urun_cnt #(.CW(CW)) u_cnt_a (
        .clk_i (dac_clk_i),
        .rst_i (dac_rst_i),
        .clr_i (urun_clr_i),
        .inc_i (urun_a),
        .cnt_o (urun_cnt_o[CH_A*CW +: CW])
    );

    dac_urun_cnt #(.CW(CW)) u_cnt_b (
        .clk_i (dac_clk_i),
        .rst_i (dac_rst_i),
        .clr_i (urun_clr_i),
        .inc_i (urun_b),
        .cnt_o (urun_cnt_o[CH_B*CW +: CW])
    );

endmodule

// File: tb/tb_dac_intlv_ctrl.sv
// tb/tb_dac_intlv_ctrl.sv - directed self-checking bench for dac_intlv_ctrl (CW = 4)
module tb_dac_intlv_ctrl;

    localparam int DW = 14;
    localparam int CW = 4;
`ifdef DAC_URUN_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            ena_i;
    logic [DW-1:0]   cha_dat_i, chb_dat_i;
    logic            cha_vld_i, chb_vld_i;
    logic            cha_rdy_o, chb_rdy_o;
    logic            urun_clr_i;
    logic [DW-1:0]   dac_dat_o;
    logic            dac_sel_o, dac_wrt_o, active_o;
    logic [2*CW-1:0] urun_cnt_o;

    int checks;
    int failures;

    dac_intlv_ctrl #(.DW(DW), .CW(CW)) dut (
        .dac_clk_i  (clk),
        .dac_rst_i  (rst),
        .ena_i      (ena_i),
        .cha_dat_i  (cha_dat_i),
        .cha_vld_i  (cha_vld_i),
        .cha_rdy_o  (cha_rdy_o),
        .chb_dat_i  (chb_dat_i),
        .chb_vld_i  (chb_vld_i),
        .chb_rdy_o  (chb_rdy_o),
        .urun_clr_i (urun_clr_i),
        .dac_dat_o  (dac_dat_o),
        .dac_sel_o  (dac_sel_o),
        .dac_wrt_o  (dac_wrt_o),
        .active_o   (active_o),
        .urun_cnt_o (urun_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Precondition: current cycle is SLOT_A. Runs one A write then one B write.
    task automatic do_pair(input logic av, input logic [DW-1:0] ad,
                           input logic bv, input logic [DW-1:0] bd,
                           input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                           input logic clr, input string name);
        cha_vld_i = av;
        cha_dat_i = ad;
        checks++;
        if ({cha_rdy_o, chb_rdy_o, active_o} !== 3'b101) begin
            failures++;
            $display("FAIL %s slot_a_flags got %b exp 101", name, {cha_rdy_o, chb_rdy_o, active_o});
        end
        step();
        checks++;
        if ({dac_dat_o, dac_sel_o, dac_wrt_o} !== {ea, 2'b00}) begin
            failures++;
            $display("FAIL %s bus_a got dat=%h sel=%b wrt=%b exp dat=%h sel=0 wrt=0",
                     name, dac_dat_o, dac_sel_o, dac_wrt_o, ea);
        end
        checks++;
        if ({cha_rdy_o, chb_rdy_o} !== 2'b01) begin
            failures++;
            $display("FAIL %s slot_b_rdy got %b exp 01", name, {cha_rdy_o, chb_rdy_o});
        end
        cha_vld_i  = 1'b0;
        chb_vld_i  = bv;
        chb_dat_i  = bd;
        urun_clr_i = clr;
        step();
        checks++;
        if ({dac_dat_o, dac_sel_o, dac_wrt_o} !== {eb, 2'b10}) begin
            failures++;
            $display("FAIL %s bus_b got dat=%h sel=%b wrt=%b exp dat=%h sel=1 wrt=0",
                     name, dac_dat_o, dac_sel_o, dac_wrt_o, eb);
        end
        chb_vld_i  = 1'b0;
        urun_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena_i = 1'b0; urun_clr_i = 1'b0;
        cha_dat_i = '0; chb_dat_i = '0; cha_vld_i = 1'b0; chb_vld_i = 1'b0;
        step();
        step();
        checks++;
        if ({dac_dat_o, dac_sel_o, dac_wrt_o, cha_rdy_o, chb_rdy_o, active_o, urun_cnt_o}
            !== {14'd0, 1'b0, 1'b1, 3'b000, 8'h00}) begin
            failures++;
            $display("FAIL reset_values got dat=%h sel=%b wrt=%b rdy=%b%b act=%b cnt=%h",
                     dac_dat_o, dac_sel_o, dac_wrt_o, cha_rdy_o, chb_rdy_o, active_o, urun_cnt_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({dac_wrt_o, cha_rdy_o, chb_rdy_o, active_o, urun_cnt_o} !== {4'b1000, 8'h00}) begin
                failures++;
                $display("FAIL idle_cycle_%0d got wrt=%b rdy=%b%b act=%b cnt=%h",
                         i, dac_wrt_o, cha_rdy_o, chb_rdy_o, active_o, urun_cnt_o);
            end
        end
    endtask

    task automatic test_stream();
        ena_i = 1'b1;
        step();
        checks++;
        if ({dac_wrt_o, cha_rdy_o, active_o} !== 3'b111) begin
            failures++;
            $display("FAIL first_slot_a got wrt=%b rdy_a=%b act=%b exp 111", dac_wrt_o, cha_rdy_o, active_o);
        end
        for (int i = 0; i < 5; i++) begin
            do_pair(1'b1, DW'(100 + i), 1'b1, DW'(-(100 + i)),
                    DW'(100 + i), DW'(-(100 + i)), 1'b0, "stream");
        end
        checks++;
        if (urun_cnt_o !== 8'h00) begin
            failures++;
            $display("FAIL stream_counts got %h exp 00", urun_cnt_o);
        end
    endtask

    task automatic test_underrun();
        do_pair(1'b1, DW'(105), 1'b1, DW'(-105), DW'(105), DW'(-105), 1'b0, "pre_urun");
        do_pair(1'b0, DW'(999), 1'b1, DW'(-106),
                ZERO_EN ? DW'(0) : DW'(105), DW'(-106), 1'b0, "urun_a");
        checks++;
        if (urun_cnt_o !== 8'h01) begin
            failures++;
            $display("FAIL urun_a_count got %h exp 01", urun_cnt_o);
        end
        do_pair(1'b1, DW'(106), 1'b1, DW'(-107), DW'(106), DW'(-107), 1'b0, "post_urun");
    endtask

    task automatic test_saturate_clear();
        for (int i = 0; i < 19; i++) begin
            do_pair(1'b1, DW'(107 + i), 1'b0, DW'(0),
                    DW'(107 + i), ZERO_EN ? DW'(0) : DW'(-107), 1'b0, "urun_b");
        end
        checks++;
        if (urun_cnt_o !== 8'hF1) begin
            failures++;
            $display("FAIL saturate_count got %h exp f1", urun_cnt_o);
        end
        do_pair(1'b1, DW'(126), 1'b0, DW'(0),
                DW'(126), ZERO_EN ? DW'(0) : DW'(-107), 1'b1, "clr_urun");
        checks++;
        if (urun_cnt_o !== 8'h00) begin
            failures++;
            $display("FAIL clear_wins got %h exp 00", urun_cnt_o);
        end
    endtask

    task automatic test_ena_drop();
        ena_i = 1'b0;
        do_pair(1'b1, DW'(200), 1'b1, DW'(-200), DW'(200), DW'(-200), 1'b0, "ena_drop");
        checks++;
        if ({active_o, cha_rdy_o, chb_rdy_o} !== 3'b000) begin
            failures++;
            $display("FAIL drop_idle got act=%b rdy=%b%b exp 000", active_o, cha_rdy_o, chb_rdy_o);
        end
        step();
        checks++;
        if ({dac_dat_o, dac_sel_o, dac_wrt_o} !== {DW'(-200), 2'b11}) begin
            failures++;
            $display("FAIL drop_wrt_high got dat=%h sel=%b wrt=%b exp dat=%h sel=1 wrt=1",
                     dac_dat_o, dac_sel_o, dac_wrt_o, DW'(-200));
        end
    endtask

    task automatic test_reset_mid();
        ena_i = 1'b1;
        step();
        cha_vld_i = 1'b0;
        step();
        chb_vld_i = 1'b1;
        chb_dat_i = DW'(-300);
        checks++;
        if ({dac_dat_o, dac_sel_o, dac_wrt_o, urun_cnt_o} !==
            {ZERO_EN ? DW'(0) : DW'(200), 2'b00, 8'h01}) begin
            failures++;
            $display("FAIL mid_pre_reset got dat=%h sel=%b wrt=%b cnt=%h",
                     dac_dat_o, dac_sel_o, dac_wrt_o, urun_cnt_o);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({dac_dat_o, dac_sel_o, dac_wrt_o, cha_rdy_o, chb_rdy_o, active_o, urun_cnt_o}
            !== {14'd0, 1'b0, 1'b1, 3'b000, 8'h00}) begin
            failures++;
            $display("FAIL async_reset got dat=%h sel=%b wrt=%b rdy=%b%b act=%b cnt=%h",
                     dac_dat_o, dac_sel_o, dac_wrt_o, cha_rdy_o, chb_rdy_o, active_o, urun_cnt_o);
        end
        #1;
        rst = 1'b0;
        chb_vld_i = 1'b0;
        step();
        do_pair(1'b0, DW'(0), 1'b0, DW'(0), DW'(0), DW'(0), 1'b0, "restart_hold0");
        checks++;
        if (urun_cnt_o !== 8'h11) begin
            failures++;
            $display("FAIL restart_counts got %h exp 11", urun_cnt_o);
        end
        ena_i = 1'b0;
        step();
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_underrun();
        test_saturate_clear();
        test_ena_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_intlv_ctrl.md
# dac_intlv_ctrl

Slot scheduler that shares the single interleaved DAC data bus between two sample streams (channel A and channel B). It accepts samples from each channel through a valid/ready handshake, alternates A/B write slots, and drives the registered bus (data, channel select, active-low write strobe) consumed by the board DAC interface. On underrun it substitutes a sample and counts the event, per channel.

## Interface
Parameters:
- DW, 14, sample width
- CW, 16, underrun counter width

Ports:
- dac_clk_i  in  1  DAC clock; the only clock
- dac_rst_i  in  1  reset, asynchronous, active-high
- ena_i  in  1  run request; sampled every cycle
- cha_dat_i  in  DW  channel A sample, two's complement
- cha_vld_i  in  1  channel A sample valid
- cha_rdy_o  out  1  channel A ready; high only in SLOT_A
- chb_dat_i  in  DW  channel B sample, two's complement
- chb_vld_i  in  1  channel B sample valid
- chb_rdy_o  out  1  channel B ready; high only in SLOT_B
- urun_clr_i  in  1  synchronous clear of both underrun counters
- dac_dat_o  out  DW  DAC bus data, registered, passed unchanged; downstream does code conversion
- dac_sel_o  out  1  channel select: 0 = A, 1 = B
- dac_wrt_o  out  1  write strobe, active-low
- active_o  out  1  high while state is SLOT_A or SLOT_B
- urun_cnt_o  out  2×CW  per-channel saturating underrun counts; [0] = A, [1] = B

## Operation
- States: IDLE, SLOT_A, SLOT_B.
- IDLE -> SLOT_A when ena_i = 1; otherwise stay in IDLE.
- SLOT_A -> SLOT_B unconditionally. A/B pairs are never split.
- SLOT_B -> SLOT_A if ena_i = 1, else -> IDLE.
- SLOT_A cycle:
  - cha_rdy_o = 1.
  - If cha_vld_i = 1: transfer; hold_a <= cha_dat_i.
  - Output registers load dat = cha_vld_i ? cha_dat_i : underrun value; sel = 0; wrt = 0.
- SLOT_B: symmetric, using chb_* and hold_b, with sel = 1.
- Underrun = slot cycle with vld = 0. The underrun value is hold_x, i.e. the last accepted sample (0 if none since reset). The channel counter increments.
- IDLE cycle: output registers load wrt = 1; dat and sel hold their previous values. Both rdy outputs are 0.
- Counters saturate at 2^CW−1 (no wrap). urun_clr_i = 1 zeroes both; clear wins over a simultaneous increment, so the result is 0.
- Handshake: rdy_o is combinational from state only and never depends on vld_i. A vld_i asserted outside the channel's slot is ignored; the source must hold the sample.
- Deasserting ena_i in SLOT_A still completes SLOT_B; the last write is always channel B.

## Timing
- Reset values:
  - state IDLE
  - dac_dat_o 0, dac_sel_o 0, dac_wrt_o 1
  - cha_rdy_o 0, chb_rdy_o 0, active_o 0
  - urun_cnt_o 0, hold_a 0, hold_b 0
- Assertion of dac_rst_i takes effect immediately, mid-slot included. Any in-flight sample is dropped.
- Latency: the sample accepted in slot cycle n appears on dac_dat_o, with its sel and wrt = 0, in cycle n+1.
- Throughput: one sample per channel every 2 cycles; dac_wrt_o is continuously low while running.
- First write after ena_i rises at edge k: state SLOT_A during cycle k+1; A data on the bus during cycle k+2.
- The counter update is visible one cycle after the underrun slot.

## Configuration
- DAC_URUN_ZERO_EN defined:
  - Underrun value = 0 (mid-scale).
  - The underrun also clears that channel's hold register.
- Not defined: underrun value = hold register (repeat last sample).
- Counting is identical in both builds.

## Structure
- Package dac_intlv_pkg:
  - state enum (IDLE, SLOT_A, SLOT_B)
  - channel index constants CH_A = 0, CH_B = 1
  - default DW/CW constants
- Sub-module dac_urun_cnt: saturating counter with synchronous clear and increment; clear has priority. Instantiated once per channel.

## Test plan
- Reset release with ena_i = 0 for 10 cycles -> dac_wrt_o = 1, both rdy = 0, active_o = 0, counts 0.
- ena_i = 1; A sources 100, 101…, B sources −100, −101…, both always valid -> bus alternates 100 (sel 0), −100 (sel 1), 101, −101…; wrt = 0 throughout; counts 0.
- A valid drops for one A slot after sample 5 ->
  - without the macro: bus repeats 5 on A.
  - with DAC_URUN_ZERO_EN: bus shows 0 on A.
  - urun_cnt_o[0] = 1, [1] = 0.
- Preload counter near saturation (CW = 4, 20 underruns on B), then urun_clr_i asserted in the same cycle as an underrun -> count stops at 15, then reads 0.
- ena_i dropped during SLOT_A -> the B write still occurs, then wrt = 1 and active_o = 0 on the following cycle.
- dac_rst_i pulsed mid-SLOT_B -> all outputs immediately take reset values; the next A write after restart uses hold 0 on underrun.
